rr_arb_mux: RTL and testbench

- Parametrised, registered N-way multiplexer. Successor to the combinational 2-way mux family.
- Selects one of CHANNELS valid/ready input streams per cycle, using round-robin or fixed-priority arbitration.
- Registers the winner into a single-entry output stage.
- Used wherever several MIPS pipeline sources share one consumer, e.g. writeback port or memory request bus.

---
 rtl/rr_arb_mux.sv | 113 +++++++++++
 tb/tb_rr_arb_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Registered N-way stream mux with round-robin (MODE=0) or fixed-priority (MODE=1) arbitration; 1-cycle latency.
// Backpressure: out_ready low freezes the output register, grant and pointer. Optional packet lock: RR_ARB_MUX_LOCK_EN.
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_lock,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    start;
  logic [SEL_W-1:0]    gidx;
  logic [SEL_W-1:0]    ptr_next;
  logic [CHANNELS-1:0] req;
  logic [WIDTH-1:0]    gdata;
  logic                found;
  logic                load_en;
  logic                xfer;
  logic                hold_lock;

`ifdef RR_ARB_MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;

  // While a packet is in flight only its owner may request.
  always_comb begin
    req = in_valid;
    if (locked) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(lock_ch) != k) req[k] = 1'b0;
      end
    end
  end

  assign hold_lock = in_lock[gidx];
`else
  assign req       = in_valid;
  assign hold_lock = 1'b0;
`endif

  assign load_en = !out_valid || out_ready;
  assign start   = (MODE == 0) ? ptr : '0;
  assign xfer    = load_en && found;

  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(start) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(gidx) == k) gdata = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gidx] = 1'b1;
  end

  assign ptr_next = (int'(gidx) == CHANNELS - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gidx;
        if (MODE == 0 && !hold_lock) ptr <= ptr_next;
`ifdef RR_ARB_MUX_LOCK_EN
        locked    <= hold_lock;
        lock_ch   <= gidx;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin instance (dut0) and fixed-priority instance (dut1), WIDTH=8, CHANNELS=4.
module tb_rr_arb_mux;

  logic        clk;
  logic        reset;
  logic [3:0]  iv0, iv1, ir0, ir1;
  logic [31:0] id0, id1;
  logic        ov0, ov1, ordy0, ordy1;
  logic [7:0]  od0, od1;
  logic [1:0]  os0, os1;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [3:0]  lock0, lock1;
`endif

  int total = 0;
  int bad   = 0;

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(id0),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock(lock0),
`endif
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0)
  );

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_data(id1),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock(lock1),
`endif
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends right after a falling edge.
  task test_reset;
    reset = 1'b1; iv0 = '0; iv1 = '0; id0 = '0; id1 = '0; ordy0 = 1'b1; ordy1 = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    lock0 = '0; lock1 = '0;
`endif
    repeat (2) @(negedge clk);
    total++;
    if (ov0 !== 1'b0 || od0 !== 8'h00 || os0 !== 2'd0) begin
      bad++; $display("FAIL reset_out0 got v=%b d=%h s=%0d exp v=0 d=00 s=0", ov0, od0, os0);
    end
    total++;
    if (ov1 !== 1'b0 || od1 !== 8'h00 || os1 !== 2'd0) begin
      bad++; $display("FAIL reset_out1 got v=%b d=%h s=%0d exp v=0 d=00 s=0", ov1, od1, os1);
    end
    total++;
    if (ir0 !== 4'b0000 || ir1 !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got %b/%b exp 0000/0000", ir0, ir1);
    end
    reset = 1'b0;
  endtask

  task test_back_to_back;
    logic [1:0] es;
    logic [3:0] er;
    id0 = {8'h13, 8'h12, 8'h11, 8'h10};
    iv0 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      es = 2'(i % 4);
      er = 4'b0001 << es;
      #1;
      total++;
      if (ir0 !== er) begin bad++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, ir0, er); end
      @(posedge clk); #1;
      total++;
      if (ov0 !== 1'b1 || os0 !== es || od0 !== 8'h10 + 8'(es)) begin
        bad++; $display("FAIL b2b_out[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", i, ov0, os0, od0, es, 8'h10 + 8'(es));
      end
      @(negedge clk);
    end
    iv0 = '0;
  endtask

  task test_backpressure;
    id0 = {8'h13, 8'hA5, 8'h11, 8'h10};
    iv0 = 4'b0100; ordy0 = 1'b1;
    #1; total++;
    if (ir0 !== 4'b0100) begin bad++; $display("FAIL bp_load_ready got %b exp 0100", ir0); end
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b1 || od0 !== 8'hA5 || os0 !== 2'd2) begin
      bad++; $display("FAIL bp_load got v=%b d=%h s=%0d exp v=1 d=a5 s=2", ov0, od0, os0);
    end
    @(negedge clk);
    ordy0 = 1'b0; iv0 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (ir0 !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d] got %b exp 0000", i, ir0); end
      @(posedge clk); #1; total++;
      if (ov0 !== 1'b1 || od0 !== 8'hA5 || os0 !== 2'd2) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=a5 s=2", i, ov0, od0, os0);
      end
      @(negedge clk);
    end
    ordy0 = 1'b1;
    #1; total++;
    if (ir0 !== 4'b1000) begin bad++; $display("FAIL bp_drain_ready got %b exp 1000", ir0); end
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b1 || od0 !== 8'h13 || os0 !== 2'd3) begin
      bad++; $display("FAIL bp_drain_load got v=%b d=%h s=%0d exp v=1 d=13 s=3", ov0, od0, os0);
    end
    @(negedge clk);
    iv0 = '0;
  endtask

  task test_wrap;
    id0 = {8'h13, 8'h12, 8'h11, 8'h10};
    iv0 = 4'b0100;
    @(posedge clk); #1; total++;
    if (os0 !== 2'd2) begin bad++; $display("FAIL wrap_setup got s=%0d exp 2", os0); end
    @(negedge clk);
    iv0 = 4'b0001;
    #1; total++;
    if (ir0 !== 4'b0001) begin bad++; $display("FAIL wrap_ready got %b exp 0001", ir0); end
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b1 || os0 !== 2'd0 || od0 !== 8'h10) begin
      bad++; $display("FAIL wrap_out got v=%b s=%0d d=%h exp v=1 s=0 d=10", ov0, os0, od0);
    end
    @(negedge clk);
    iv0 = 4'hF;
    #1; total++;
    if (ir0 !== 4'b0010) begin bad++; $display("FAIL wrap_ptr got %b exp 0010", ir0); end
    @(posedge clk); #1;
    @(negedge clk);
    iv0 = 4'b0000;
    #1; total++;
    if (ir0 !== 4'b0000) begin bad++; $display("FAIL idle_ready got %b exp 0000", ir0); end
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b0 || os0 !== 2'd1 || od0 !== 8'h11) begin
      bad++; $display("FAIL idle_out got v=%b s=%0d d=%h exp v=0 s=1 d=11", ov0, os0, od0);
    end
    @(negedge clk);
  endtask

  task test_fixed;
    id1 = {8'h23, 8'h22, 8'h21, 8'h20};
    iv1 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (ir1 !== 4'b0010) begin bad++; $display("FAIL fixed_ready[%0d] got %b exp 0010", i, ir1); end
      @(posedge clk); #1; total++;
      if (ov1 !== 1'b1 || os1 !== 2'd1 || od1 !== 8'h21) begin
        bad++; $display("FAIL fixed_out[%0d] got v=%b s=%0d d=%h exp v=1 s=1 d=21", i, ov1, os1, od1);
      end
      @(negedge clk);
    end
    iv1 = 4'b1000;
    #1; total++;
    if (ir1 !== 4'b1000) begin bad++; $display("FAIL fixed_ch3_ready got %b exp 1000", ir1); end
    @(posedge clk); #1; total++;
    if (os1 !== 2'd3 || od1 !== 8'h23) begin
      bad++; $display("FAIL fixed_ch3_out got s=%0d d=%h exp s=3 d=23", os1, od1);
    end
    @(negedge clk);
    iv1 = 4'hF;
    #1; total++;
    if (ir1 !== 4'b0001) begin bad++; $display("FAIL fixed_all_ready got %b exp 0001", ir1); end
    @(posedge clk); #1; total++;
    if (os1 !== 2'd0 || od1 !== 8'h20) begin
      bad++; $display("FAIL fixed_all_out got s=%0d d=%h exp s=0 d=20", os1, od1);
    end
    @(negedge clk);
    iv1 = '0;
  endtask

  task test_async_reset;
    id0 = {8'h13, 8'hA5, 8'h11, 8'h10};
    iv0 = 4'b0100; ordy0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    iv0 = '0; ordy0 = 1'b0;
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b1 || od0 !== 8'hA5) begin
      bad++; $display("FAIL areset_pre got v=%b d=%h exp v=1 d=a5", ov0, od0);
    end
    #2 reset = 1'b1;
    #1; total++;
    if (ov0 !== 1'b0 || od0 !== 8'h00 || os0 !== 2'd0) begin
      bad++; $display("FAIL areset_now got v=%b d=%h s=%0d exp v=0 d=00 s=0", ov0, od0, os0);
    end
    @(negedge clk);
    reset = 1'b0; ordy0 = 1'b1; iv0 = 4'hF;
    id0 = {8'h13, 8'h12, 8'h11, 8'h10};
    #1; total++;
    if (ir0 !== 4'b0001) begin bad++; $display("FAIL areset_ptr_ready got %b exp 0001", ir0); end
    @(posedge clk); #1; total++;
    if (ov0 !== 1'b1 || os0 !== 2'd0 || od0 !== 8'h10) begin
      bad++; $display("FAIL areset_first got v=%b s=%0d d=%h exp v=1 s=0 d=10", ov0, os0, od0);
    end
    @(negedge clk);
    iv0 = '0;
  endtask

`ifdef RR_ARB_MUX_LOCK_EN
  task test_lock;
    logic [7:0] ed;
    iv0 = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      ed = 8'hB0 + 8'(i);
      id0 = {8'h13, 8'h12, ed, 8'h10};
      lock0 = (i < 2) ? 4'b0010 : 4'b0000;
      #1; total++;
      if (ir0 !== 4'b0010) begin bad++; $display("FAIL lock_ready[%0d] got %b exp 0010", i, ir0); end
      @(posedge clk); #1; total++;
      if (os0 !== 2'd1 || od0 !== ed) begin
        bad++; $display("FAIL lock_out[%0d] got s=%0d d=%h exp s=1 d=%h", i, os0, od0, ed);
      end
      @(negedge clk);
    end
    lock0 = '0;
    #1; total++;
    if (ir0 !== 4'b0100) begin bad++; $display("FAIL lock_release_ready got %b exp 0100", ir0); end
    @(posedge clk); #1; total++;
    if (os0 !== 2'd2 || od0 !== 8'h12) begin
      bad++; $display("FAIL lock_release_out got s=%0d d=%h exp s=2 d=12", os0, od0);
    end
    @(negedge clk);
    iv0 = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_wrap;
    test_fixed;
    test_async_reset;
`ifdef RR_ARB_MUX_LOCK_EN
    test_lock;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
